// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one variable-latency memory between instruction fetch and data access,
// with a starvation guard for fetch and a watchdog that aborts hung accesses.
module pipe_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic        err_sticky
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;
  logic [1:0]    r_state;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_if_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
  logic          r_if_done, r_d_done, r_mem_we, r_err, r_err_sticky;
  logic          w_busy, w_tmo, w_d_grant;
  assign w_busy    = (r_state == BUSY_IF) || (r_state == BUSY_D);
  assign w_tmo     = r_timer == TW'(TIMEOUT - 1);
  // data wins unless fetch has already been passed over STARVE_MAX times in a row
  assign w_d_grant = d_req & ~(if_req & (r_starve == SW'(STARVE_MAX)));
  assign if_rdata   = r_if_rdata;
  assign if_done    = r_if_done;
  assign if_stall   = if_req & ~r_if_done;
  assign d_rdata    = r_d_rdata;
  assign d_done     = r_d_done;
  assign d_stall    = d_req & ~r_d_done;
  assign mem_req    = w_busy;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_starve     <= '0;
      r_timer      <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_done    <= 1'b0;
      r_d_done     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_d_grant) begin
            r_state     <= BUSY_D;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_timer     <= '0;
            r_starve    <= !if_req ? '0 :
                           (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + 1'b1;
          end else if (if_req) begin
            r_state    <= BUSY_IF;
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr;
            r_timer    <= '0;
            r_starve   <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (mem_ack || w_tmo) begin
            r_state <= RESP;
            if (r_state == BUSY_IF) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= mem_ack ? mem_rdata : 32'hDEADBEEF;
            end else begin
              r_d_done <= 1'b1;
              if (!r_mem_we) r_d_rdata <= mem_ack ? mem_rdata : 32'hDEADBEEF;
            end
            r_err <= ~mem_ack;
            if (!mem_ack) r_err_sticky <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed checks of arbitration, starvation guard, watchdog and async reset.
module tb_pipe_mem_arbiter;
  logic        clock = 1'b0, resetn = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, d_done, d_stall, mem_req, mem_we, err, err_sticky;
  int          checks = 0, failures = 0;

  pipe_mem_arbiter dut (
    .clock(clock), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic exp_if;
    repeat (2) @(negedge clock);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_flags", {if_done, d_done, err, err_sticky, mem_we}, 0);
    resetn = 1'b1;
    @(negedge clock);
    // fetch only
    if_req = 1'b1; if_addr = 32'h40;
    #1 chk("t1_stall_pre", 32'(if_stall), 1);
    @(negedge clock);
    chk("t1_busy", {mem_req, mem_we}, 32'b10);
    chk("t1_addr", mem_addr, 32'h40);
    chk("t1_stall_busy", 32'(if_stall), 1);
    mem_ack = 1'b1; mem_rdata = 32'h8C220004;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("t1_done", {if_done, d_done, err, mem_req}, 32'b1000);
    chk("t1_rdata", if_rdata, 32'h8C220004);
    chk("t1_stall_done", 32'(if_stall), 0);
    if_req = 1'b0;
    @(negedge clock);
    chk("t1_idle", {if_done, mem_req}, 0);
    // simultaneous write and fetch: data first
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55;
    @(negedge clock);
    chk("t2_d_busy", {mem_req, mem_we}, 32'b11);
    chk("t2_d_addr", mem_addr, 32'h100);
    chk("t2_d_wdata", mem_wdata, 32'h55);
    chk("t2_stalls", {if_stall, d_stall}, 32'b11);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("t2_d_done", {d_done, if_done}, 32'b10);
    chk("t2_d_rdata_kept", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clock);
    chk("t2_idle", {mem_req, d_done}, 0);
    @(negedge clock);
    chk("t2_if_busy", {mem_req, mem_we}, 32'b10);
    chk("t2_if_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'hAABBCCDD;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("t2_if_done", {if_done, d_done}, 32'b10);
    chk("t2_if_rdata", if_rdata, 32'hAABBCCDD);
    if_req = 1'b0;
    @(negedge clock);
    // starvation: both held; expect D x4, IF, D x4, IF
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int g = 0; g < 10; g++) begin
      exp_if = (g == 4) || (g == 9);
      @(negedge clock);
      chk($sformatf("t3_addr%0d", g), mem_addr, exp_if ? 32'h300 : 32'h400);
      chk($sformatf("t3_req%0d", g), 32'(mem_req), 1);
      mem_ack = 1'b1; mem_rdata = 32'(g + 1);
      @(negedge clock);
      mem_ack = 1'b0;
      chk($sformatf("t3_done%0d", g), {if_done, d_done}, exp_if ? 32'b10 : 32'b01);
      chk($sformatf("t3_rdata%0d", g), exp_if ? if_rdata : d_rdata, 32'(g + 1));
      @(negedge clock);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    // watchdog on a data read that never acks
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    @(negedge clock);
    n = 0;
    while (mem_req && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk("t4_busy_cycles", n, 64);
    chk("t4_done", {d_done, err, err_sticky, mem_req}, 32'b1110);
    chk("t4_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    @(negedge clock);
    chk("t4_after", {err, err_sticky, d_done}, 32'b010);
    // ack in the last permitted cycle wins over the timeout
    if_req = 1'b1; if_addr = 32'h600;
    @(negedge clock);
    repeat (63) @(negedge clock);
    chk("t5_still_busy", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("t5_done", {if_done, err, err_sticky}, 32'b101);
    chk("t5_rdata", if_rdata, 32'h0BADF00D);
    if_req = 1'b0;
    @(negedge clock);
    // async reset mid data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    @(negedge clock);
    chk("t6_busy", 32'(mem_req), 1);
    #2 resetn = 1'b0;
    #1 chk("t6_rst_now", {mem_req, d_done, err_sticky}, 0);
    d_req = 1'b0;
    @(negedge clock);
    chk("t6_in_rst", {mem_req, d_done}, 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("t6_released", {mem_req, d_done, mem_addr}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
Arbiter and sequencer that shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its data-memory port. It serialises requests and returns read data to the right requester. It generates stall signals, which the pipeline uses to freeze the PC/IR and downstream registers. A starvation guard keeps fetch moving, and a watchdog aborts a hung memory access.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while a fetch request is pending; the next grant then goes to fetch.
TIMEOUT, 64, maximum cycles in a BUSY state without mem_ack before the access is aborted (minimum 2).

Ports:
clock  in  1  single clock; all state updates on the rising edge.
resetn  in  1  asynchronous, active-low reset.
if_req  in  1  fetch read request; level-held until if_done.
if_addr  in  32  fetch address.
if_rdata  out  32  fetched instruction; registered.
if_done  out  1  one-cycle pulse marking if_rdata valid.
if_stall  out  1  if_req & ~if_done (combinational).
d_req  in  1  data request; level-held until d_done.
d_we  in  1  1 = write, 0 = read.
d_addr  in  32  data address.
d_wdata  in  32  write data.
d_rdata  out  32  load data; registered.
d_done  out  1  one-cycle completion pulse.
d_stall  out  1  d_req & ~d_done (combinational).
mem_req  out  1  memory access request; held until mem_ack.
mem_we  out  1  memory write enable.
mem_addr  out  32  latched access address.
mem_wdata  out  32  latched write data.
mem_rdata  in  32  valid in the mem_ack cycle.
mem_ack  in  1  one-cycle completion from memory.
err  out  1  one-cycle pulse on a watchdog abort.
err_sticky  out  1  set on any abort; cleared only by reset.

Behaviour:
- Reset state: state=IDLE. All outputs are 0, including rdata registers, mem_* signals, done signals, err, err_sticky, starve_cnt and timer.
- States are IDLE, BUSY_IF, BUSY_D and RESP.
- IDLE, grant selection:
  - If d_req=1, and not (if_req=1 and starve_cnt==STARVE_MAX): go to BUSY_D. Latch d_we, d_addr and d_wdata into mem_we, mem_addr and mem_wdata.
  - Otherwise, if if_req=1: go to BUSY_IF. Latch if_addr; mem_we=0.
  - No request: remain in IDLE.
- Starvation counter: on a D grant with if_req=1, starve_cnt increments (saturating at STARVE_MAX). On an IF grant, or a D grant with if_req=0, starve_cnt clears to 0.
- mem_req is 1 exactly while in BUSY_IF or BUSY_D. mem_addr, mem_we and mem_wdata stay stable throughout BUSY.
- BUSY_x with mem_ack=1: capture mem_rdata into x_rdata (reads only; a data write leaves d_rdata unchanged) and go to RESP. x_done=1 during RESP.
- Timer:
  - Counts cycles in BUSY and clears on BUSY entry.
  - If mem_ack is still 0 when the timer reaches TIMEOUT-1: go to RESP with x_rdata=32'hDEADBEEF (reads only), pulse err=1 in RESP, and set err_sticky.
  - A mem_ack arriving in that same cycle wins; no error is raised.
- RESP: lasts one cycle and always returns to IDLE. Requests are not sampled in RESP.
- Requester contract: the requester deasserts req in the cycle after done. A req still high in IDLE is treated as a new access.
- Minimum latency: req at cycle 0, BUSY at cycle 1, ack at cycle 1, done at cycle 2, IDLE at cycle 3. Back-to-back accesses from one port therefore take 3 cycles each.
- mem_ack outside BUSY is ignored.
- Reset asserted mid-access: return to the reset state immediately. Any pending access is dropped with no done pulse.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x40, mem_ack one cycle after mem_req with mem_rdata=0x8C220004 -> if_done pulses 1 cycle later, if_rdata=0x8C220004, if_stall=1 until done.
2. Simultaneous if_req and d_req, d_we=1, d_addr=0x100, d_wdata=0x55 -> data served first with mem_we=1, mem_wdata=0x55, d_rdata unchanged. Fetch follows with mem_we=0, mem_addr=if_addr.
3. Starvation: if_req held high while d_req is re-asserted continuously -> exactly 4 D grants, then an IF grant; starve_cnt returns to 0.
4. Memory never acks on a data read -> mem_req drops after 64 BUSY cycles, d_rdata=0xDEADBEEF, d_done=1, err pulses, err_sticky stays 1 for later transactions.
5. mem_ack arrives in cycle 63 -> normal completion, err=0.
6. resetn=0 in BUSY_D with mem_req=1 -> mem_req=0 immediately, no d_done, state IDLE after release.
